// File: rtl/wload_pkg.sv
// Shared types and defaults for the column weight loader (wload_feeder).
package wload_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_ROWS  = 4;

   // ROWS is at least 2, so this is never zero.
   function automatic int cnt_w(input int rows);
      return $clog2(rows);
   endfunction

endpackage

// File: rtl/wload_buf.sv
// ROWS x WIDTH tile buffer: one synchronous write port, one combinational read port.
module wload_buf
   import wload_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ROWS  = DEF_ROWS,
   parameter int AW    = cnt_w(DEF_ROWS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [ROWS-1:0][WIDTH-1:0] mem_q, mem_d;

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) mem_q <= '0;
      else     mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/wload_feeder.sv
// Column weight loader: gathers ROWS words, then shifts them deepest-first into the chain.
// Optional all-zero tile shortcut (clear instead of shift) under WLOAD_ZERO_SKIP_EN.
module wload_feeder
   import wload_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ROWS  = DEF_ROWS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_clr_req,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_wvalid,
   output logic             o_wready,
   input  logic             i_hold,
   output logic [WIDTH-1:0] o_data,
   output logic             o_en,
   output logic             o_clr,
   output logic             o_busy,
   output logic             o_done
);

   localparam int            CW   = cnt_w(ROWS);
   localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             en_q, en_d;
   logic             clr_q, clr_d;
   logic             done_q, done_d;
   logic             hs;
   logic [CW-1:0]    buf_raddr;
   logic [WIDTH-1:0] buf_rdata;
`ifdef WLOAD_ZERO_SKIP_EN
   logic             zero_q, zero_d;
`endif

   assign hs        = i_wvalid && (state_q == FILL);
   // Deepest row leaves first, so read the buffer back to front.
   assign buf_raddr = LAST - cnt_q;

   wload_buf #(.WIDTH(WIDTH), .ROWS(ROWS), .AW(CW)) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (hs),
      .waddr (cnt_q),
      .wdata (i_wdata),
      .raddr (buf_raddr),
      .rdata (buf_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      en_d    = 1'b0;
      clr_d   = 1'b0;
      done_d  = 1'b0;
`ifdef WLOAD_ZERO_SKIP_EN
      zero_d  = zero_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_clr_req) clr_d = 1'b1;
            if (i_start) begin
               state_d = FILL;
               cnt_d   = '0;
`ifdef WLOAD_ZERO_SKIP_EN
               zero_d  = 1'b1;
`endif
            end
         end
         FILL: begin
            if (hs) begin
               cnt_d = cnt_q + 1'b1;
`ifdef WLOAD_ZERO_SKIP_EN
               zero_d = zero_q && (i_wdata == '0);
`endif
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = SHIFT;
`ifdef WLOAD_ZERO_SKIP_EN
                  if (zero_d) state_d = DONE;
`endif
               end
            end
         end
         SHIFT: begin
            if (!i_hold) begin
               en_d   = 1'b1;
               data_d = buf_rdata;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef WLOAD_ZERO_SKIP_EN
            // A skipped zero tile is delivered as a chain clear.
            clr_d   = zero_q;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         en_q    <= 1'b0;
         clr_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef WLOAD_ZERO_SKIP_EN
         zero_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         en_q    <= en_d;
         clr_q   <= clr_d;
         done_q  <= done_d;
`ifdef WLOAD_ZERO_SKIP_EN
         zero_q  <= zero_d;
`endif
      end
   end

   assign o_wready = (state_q == FILL);
   assign o_busy   = (state_q != IDLE);
   assign o_data   = data_q;
   assign o_en     = en_q;
   assign o_clr    = clr_q;
   assign o_done   = done_q;

endmodule
